// File: rtl/playfield_pkg.sv
// Shared command/state types and the grid indexing helper for the playfield engine.
package playfield_pkg;

   localparam int CMD_W = 3;

   typedef enum logic [CMD_W-1:0] {
      CMD_NOP    = 3'd0,
      CMD_DOWN   = 3'd1,
      CMD_LEFT   = 3'd2,
      CMD_RIGHT  = 3'd3,
      CMD_ROTATE = 3'd4,
      CMD_DROP   = 3'd5
   } cmd_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACTIVE,
      S_DROP,
      S_LOCK,
      S_CLEAR,
      S_OVER
   } state_e;

   // Grid bit index of a 1-based (x, y) cell; row 1 is the top row.
   function automatic int cell_idx(input int x, input int y, input int cols);
      return (y - 1) * cols + (x - 1);
   endfunction

endpackage

// File: rtl/playfield_engine_cell_free_check.sv
// Combinational test that four candidate cells are inside the field and unoccupied.
module cell_free_check
   import playfield_pkg::*;
#(
   parameter int COLS = 10,
   parameter int ROWS = 20,
   parameter int XW   = $clog2(COLS + 2),
   parameter int YW   = $clog2(ROWS + 2)
) (
   input  logic [ROWS*COLS-1:0] field,
   input  logic [4*XW-1:0]      xs,
   input  logic [4*YW-1:0]      ys,
   output logic                 all_free
);

   localparam int IW = $clog2(ROWS * COLS);

   int            cx;
   int            cy;
   logic [IW-1:0] idx;

   // NOTE: every signal written here gets a default before any branch, so no latch is inferred.
   always_comb begin
      all_free = 1'b1;
      cx       = 0;
      cy       = 0;
      idx      = '0;
      for (int i = 0; i < 4; i++) begin
         cx  = int'(xs[i*XW +: XW]);
         cy  = int'(ys[i*YW +: YW]);
         idx = IW'(cell_idx(cx, cy, COLS));
         if (cx < 1 || cx > COLS || cy < 1 || cy > ROWS) begin
            all_free = 1'b0;
         end else if (field[idx]) begin
            all_free = 1'b0;
         end
      end
   end

endmodule

// File: rtl/playfield_engine.sv
// Playfield owner: spawns and moves one 4-cell piece, locks it, then compacts full rows.
module playfield_engine
   import playfield_pkg::*;
#(
   parameter int COLS  = 10,
   parameter int ROWS  = 20,
   parameter int XW    = $clog2(COLS + 2),
   parameter int YW    = $clog2(ROWS + 2),
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 spawn_valid,
   output logic                 spawn_ready,
   input  logic [4*XW-1:0]      spawn_x,
   input  logic [4*YW-1:0]      spawn_y,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [CMD_W-1:0]     cmd,
   input  logic [4*XW-1:0]      rot_x,
   input  logic [4*YW-1:0]      rot_y,
   output logic                 cmd_done,
   output logic                 cmd_ok,
   output logic [4*XW-1:0]      piece_x,
   output logic [4*YW-1:0]      piece_y,
   output logic [ROWS*COLS-1:0] grid,
   output logic                 locked,
   output logic [CNT_W-1:0]     lines_cleared,
   output logic                 game_over
);

   localparam int N  = ROWS * COLS;
   localparam int IW = $clog2(N);

   state_e           state, state_n;
   logic [N-1:0]     field, field_n, piece_mask;
   logic [4*XW-1:0]  px, px_n, tx;
   logic [4*YW-1:0]  py, py_n, ty;
   logic [YW-1:0]    row, row_n;
   logic [CNT_W-1:0] lines_n;
   logic             over_n, done_n, ok_n, locked_n;
   logic             moved, moved_n;
   logic             move_free, rot_free, spawn_free;
   logic             row_full;
   int               mx, my;
   logic [IW-1:0]    midx;

   // Move target: one row down while dropping or on DOWN, one column sideways on LEFT/RIGHT.
   always_comb begin
      tx = px;
      ty = py;
      for (int i = 0; i < 4; i++) begin
         if (state == S_DROP || cmd == CMD_DOWN) begin
            ty[i*YW +: YW] = py[i*YW +: YW] + YW'(1);
         end else if (cmd == CMD_LEFT) begin
            tx[i*XW +: XW] = px[i*XW +: XW] - XW'(1);
         end else if (cmd == CMD_RIGHT) begin
            tx[i*XW +: XW] = px[i*XW +: XW] + XW'(1);
         end
      end
   end

   cell_free_check #(.COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW)) u_move_check (
      .field(field), .xs(tx), .ys(ty), .all_free(move_free)
   );

   cell_free_check #(.COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW)) u_rot_check (
      .field(field), .xs(rot_x), .ys(rot_y), .all_free(rot_free)
   );

   cell_free_check #(.COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW)) u_spawn_check (
      .field(field), .xs(spawn_x), .ys(spawn_y), .all_free(spawn_free)
   );

   // Piece cells as a grid mask; coordinates of 0 (no piece) fall outside and are skipped.
   always_comb begin
      piece_mask = '0;
      mx         = 0;
      my         = 0;
      midx       = '0;
      for (int i = 0; i < 4; i++) begin
         mx   = int'(px[i*XW +: XW]);
         my   = int'(py[i*YW +: YW]);
         midx = IW'(cell_idx(mx, my, COLS));
         if (mx >= 1 && mx <= COLS && my >= 1 && my <= ROWS) begin
            piece_mask[midx] = 1'b1;
         end
      end
   end

   always_comb begin
      row_full = 1'b0;
      for (int k = 1; k <= ROWS; k++) begin
         if (int'(row) == k) row_full = &field[(k-1)*COLS +: COLS];
      end
   end

   always_comb begin
      state_n  = state;
      field_n  = field;
      px_n     = px;
      py_n     = py;
      row_n    = row;
      lines_n  = lines_cleared;
      over_n   = game_over;
      moved_n  = moved;
      done_n   = 1'b0;
      ok_n     = 1'b0;
      locked_n = 1'b0;
      case (state)
         S_IDLE: begin
            if (spawn_valid) begin
               if (spawn_free) begin
                  px_n    = spawn_x;
                  py_n    = spawn_y;
                  state_n = S_ACTIVE;
               end else begin
                  over_n  = 1'b1;
                  state_n = S_OVER;
               end
            end
         end
         S_ACTIVE: begin
            if (cmd_valid) begin
               done_n = 1'b1;
               case (cmd_e'(cmd))
                  CMD_NOP: ok_n = 1'b1;
                  CMD_DOWN: begin
                     if (move_free) begin
                        py_n = ty;
                        ok_n = 1'b1;
                     end else begin
                        state_n = S_LOCK;
                     end
                  end
                  CMD_LEFT, CMD_RIGHT: begin
                     if (move_free) begin
                        px_n = tx;
                        ok_n = 1'b1;
                     end
                  end
                  CMD_ROTATE: begin
                     if (rot_free) begin
                        px_n = rot_x;
                        py_n = rot_y;
                        ok_n = 1'b1;
                     end
                  end
                  CMD_DROP: begin
                     done_n  = 1'b0;
                     moved_n = 1'b0;
                     state_n = S_DROP;
                  end
                  default: ok_n = 1'b0;
               endcase
            end
         end
         S_DROP: begin
            if (move_free) begin
               py_n    = ty;
               moved_n = 1'b1;
            end else begin
               done_n  = 1'b1;
               ok_n    = moved;
               state_n = S_LOCK;
            end
         end
         S_LOCK: begin
            field_n  = field | piece_mask;
            locked_n = 1'b1;
            px_n     = '0;
            py_n     = '0;
            row_n    = YW'(ROWS);
            state_n  = S_CLEAR;
         end
         S_CLEAR: begin
            if (row == '0) begin
               state_n = S_IDLE;
            end else if (row_full) begin
               // Rows above shift down by one; the scan row is rechecked next cycle.
               for (int k = 1; k <= ROWS; k++) begin
                  if (k == 1) begin
                     field_n[0 +: COLS] = '0;
                  end else if (k <= int'(row)) begin
                     field_n[(k-1)*COLS +: COLS] = field[(k-2)*COLS +: COLS];
                  end
               end
               if (lines_cleared != '1) lines_n = lines_cleared + CNT_W'(1);
            end else begin
               row_n = row - YW'(1);
               if (row == YW'(1)) state_n = S_IDLE;
            end
         end
         S_OVER: begin
         end
         default: state_n = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= S_IDLE;
         // NOTE: the field is a plain flop array, not a RAM, so it is cleared by reset like any register.
         field         <= '0;
         px            <= '0;
         py            <= '0;
         row           <= '0;
         lines_cleared <= '0;
         game_over     <= 1'b0;
         moved         <= 1'b0;
         cmd_done      <= 1'b0;
         cmd_ok        <= 1'b0;
         locked        <= 1'b0;
      end else begin
         state         <= state_n;
         field         <= field_n;
         px            <= px_n;
         py            <= py_n;
         row           <= row_n;
         lines_cleared <= lines_n;
         game_over     <= over_n;
         moved         <= moved_n;
         cmd_done      <= done_n;
         cmd_ok        <= ok_n;
         locked        <= locked_n;
      end
   end

   assign spawn_ready = (state == S_IDLE);
   assign cmd_ready   = (state == S_ACTIVE);
   assign piece_x     = px;
   assign piece_y     = py;
   assign grid        = field | piece_mask;

endmodule

// File: tb/tb_playfield_engine.sv
// Directed bench for playfield_engine: command table on a live piece plus drop, clear, game-over and reset sequences.
module tb_playfield_engine;

   localparam int COLS = 10;
   localparam int ROWS = 20;
   localparam int XW   = 4;
   localparam int YW   = 5;
   localparam int N    = ROWS * COLS;

   localparam logic [2:0] C_NOP    = 3'd0;
   localparam logic [2:0] C_DOWN   = 3'd1;
   localparam logic [2:0] C_LEFT   = 3'd2;
   localparam logic [2:0] C_RIGHT  = 3'd3;
   localparam logic [2:0] C_ROTATE = 3'd4;
   localparam logic [2:0] C_DROP   = 3'd5;

   logic            clk = 1'b0;
   logic            reset;
   logic            spawn_valid, spawn_ready;
   logic [4*XW-1:0] spawn_x, rot_x, piece_x;
   logic [4*YW-1:0] spawn_y, rot_y, piece_y;
   logic            cmd_valid, cmd_ready;
   logic [2:0]      cmd;
   logic            cmd_done, cmd_ok, locked, game_over;
   logic [N-1:0]    grid;
   logic [15:0]     lines_cleared;

   int n_tests = 0;
   int n_fail  = 0;

   playfield_engine #(.COLS(COLS), .ROWS(ROWS), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
      .spawn_x(spawn_x), .spawn_y(spawn_y),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
      .rot_x(rot_x), .rot_y(rot_y),
      .cmd_done(cmd_done), .cmd_ok(cmd_ok),
      .piece_x(piece_x), .piece_y(piece_y), .grid(grid),
      .locked(locked), .lines_cleared(lines_cleared), .game_over(game_over)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]      c;
      logic [4*XW-1:0] rx;
      logic [4*YW-1:0] ry;
      logic            ok;
      logic [4*XW-1:0] ex;
      logic [4*YW-1:0] ey;
   } vec_t;

   vec_t vecs[14];

   function automatic logic [4*XW-1:0] px4(input int a, input int b, input int c, input int d);
      return {XW'(d), XW'(c), XW'(b), XW'(a)};
   endfunction

   function automatic logic [4*YW-1:0] py4(input int a, input int b, input int c, input int d);
      return {YW'(d), YW'(c), YW'(b), YW'(a)};
   endfunction

   function automatic logic [N-1:0] cb(input int x, input int y);
      logic [N-1:0] v;
      v = '0;
      v[(y-1)*COLS + (x-1)] = 1'b1;
      return v;
   endfunction

   function automatic vec_t mkv(input logic [2:0] c, input logic [4*XW-1:0] rx, input logic [4*YW-1:0] ry,
                                input logic ok, input logic [4*XW-1:0] ex, input logic [4*YW-1:0] ey);
      vec_t v;
      v.c = c; v.rx = rx; v.ry = ry; v.ok = ok; v.ex = ex; v.ey = ey;
      return v;
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      reset = 1'b0;
      spawn_valid = 1'b0;
      cmd_valid = 1'b0;
      tick;
      tick;
      reset = 1'b1;
   endtask

   task automatic do_spawn(input logic [4*XW-1:0] xs, input logic [4*YW-1:0] ys);
      int n;
      n = 0;
      while (!spawn_ready && n < 60) begin tick; n++; end
      check("spawn_ready before spawn", spawn_ready, 1'b1);
      spawn_x = xs;
      spawn_y = ys;
      spawn_valid = 1'b1;
      tick;
      spawn_valid = 1'b0;
   endtask

   task automatic do_cmd(input logic [2:0] c, input logic [4*XW-1:0] rx, input logic [4*YW-1:0] ry,
                         output logic ok, output int waits);
      int n;
      n = 0;
      while (!cmd_ready && n < 60) begin tick; n++; end
      check("cmd_ready before cmd", cmd_ready, 1'b1);
      cmd = c;
      rot_x = rx;
      rot_y = ry;
      cmd_valid = 1'b1;
      tick;
      cmd_valid = 1'b0;
      waits = 0;
      while (!cmd_done && waits < 100) begin tick; waits++; end
      check("cmd_done seen", cmd_done, 1'b1);
      ok = cmd_ok;
   endtask

   task automatic wait_idle(input int limit, output int n);
      n = 0;
      while (!spawn_ready && n < limit) begin tick; n++; end
      check("back to idle", spawn_ready, 1'b1);
   endtask

   task automatic place(input logic [4*XW-1:0] xs, input logic [4*YW-1:0] ys, input logic [2:0] c,
                        output logic ok);
      int w;
      do_spawn(xs, ys);
      do_cmd(c, '0, '0, ok, w);
      wait_idle(40, w);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok;
      int   w;
      logic [N-1:0] g;

      reset = 1'b0; spawn_valid = 1'b0; cmd_valid = 1'b0; cmd = C_NOP;
      spawn_x = '0; spawn_y = '0; rot_x = '0; rot_y = '0;

      // Command table on a square spawned at (5..6, 1..2) on an empty field.
      vecs[0]  = mkv(C_NOP,    '0, '0, 1'b1, px4(5,6,5,6), py4(1,1,2,2));
      vecs[1]  = mkv(C_LEFT,   '0, '0, 1'b1, px4(4,5,4,5), py4(1,1,2,2));
      vecs[2]  = mkv(C_RIGHT,  '0, '0, 1'b1, px4(5,6,5,6), py4(1,1,2,2));
      vecs[3]  = mkv(C_DOWN,   '0, '0, 1'b1, px4(5,6,5,6), py4(2,2,3,3));
      vecs[4]  = mkv(C_ROTATE, px4(5,5,5,5), py4(2,3,4,5), 1'b1, px4(5,5,5,5), py4(2,3,4,5));
      vecs[5]  = mkv(C_LEFT,   '0, '0, 1'b1, px4(4,4,4,4), py4(2,3,4,5));
      vecs[6]  = mkv(C_LEFT,   '0, '0, 1'b1, px4(3,3,3,3), py4(2,3,4,5));
      vecs[7]  = mkv(C_LEFT,   '0, '0, 1'b1, px4(2,2,2,2), py4(2,3,4,5));
      vecs[8]  = mkv(C_LEFT,   '0, '0, 1'b1, px4(1,1,1,1), py4(2,3,4,5));
      vecs[9]  = mkv(C_LEFT,   '0, '0, 1'b0, px4(1,1,1,1), py4(2,3,4,5));
      vecs[10] = mkv(C_ROTATE, px4(0,1,1,1), py4(2,3,4,5), 1'b0, px4(1,1,1,1), py4(2,3,4,5));
      vecs[11] = mkv(C_RIGHT,  '0, '0, 1'b1, px4(2,2,2,2), py4(2,3,4,5));
      vecs[12] = mkv(C_ROTATE, px4(2,2,2,2), py4(18,19,20,21), 1'b0, px4(2,2,2,2), py4(2,3,4,5));
      vecs[13] = mkv(C_DOWN,   '0, '0, 1'b1, px4(2,2,2,2), py4(3,4,5,6));

      // Reset state.
      apply_reset;
      check("reset spawn_ready", spawn_ready, 1'b1);
      check("reset cmd_ready", cmd_ready, 1'b0);
      check("reset grid", grid, '0);
      check("reset lines", lines_cleared, 16'd0);
      check("reset game_over", game_over, 1'b0);
      check("reset piece_y", piece_y, '0);
      check("reset pulses", {cmd_done, locked}, 2'b00);

      // Spawn the square.
      do_spawn(px4(5,6,5,6), py4(1,1,2,2));
      check("spawn spawn_ready", spawn_ready, 1'b0);
      check("spawn cmd_ready", cmd_ready, 1'b1);
      check("spawn piece_x", piece_x, px4(5,6,5,6));
      check("spawn piece_y", piece_y, py4(1,1,2,2));
      check("spawn grid", grid, cb(5,1) | cb(6,1) | cb(5,2) | cb(6,2));

      for (int i = 0; i < 14; i++) begin
         do_cmd(vecs[i].c, vecs[i].rx, vecs[i].ry, ok, w);
         check($sformatf("vec%0d latency", i), w, 0);
         check($sformatf("vec%0d cmd_ok", i), ok, vecs[i].ok);
         check($sformatf("vec%0d piece_x", i), piece_x, vecs[i].ex);
         check($sformatf("vec%0d piece_y", i), piece_y, vecs[i].ey);
      end

      // Drop on an empty field: 18 moves, lock at rows 19-20, idle within ROWS+4.
      apply_reset;
      do_spawn(px4(5,6,5,6), py4(1,1,2,2));
      do_cmd(C_DROP, '0, '0, ok, w);
      check("drop moves", w - 1, 18);
      check("drop cmd_ok", ok, 1'b1);
      check("drop landed y", piece_y, py4(19,19,20,20));
      check("drop locked before", locked, 1'b0);
      tick;
      check("drop locked pulse", locked, 1'b1);
      g = cb(5,19) | cb(6,19) | cb(5,20) | cb(6,20);
      check("drop field", grid, g);
      check("drop piece cleared", piece_x, '0);
      wait_idle(ROWS + 4, w);
      check("drop idle budget", w <= ROWS + 4, 1'b1);
      check("drop no clear", lines_cleared, 16'd0);

      // Rotate into an occupied cell, then a blocked DOWN locks the piece.
      do_spawn(px4(1,2,1,2), py4(1,1,2,2));
      do_cmd(C_ROTATE, px4(5,6,1,2), py4(19,19,3,3), ok, w);
      check("rotate occupied ok", ok, 1'b0);
      check("rotate occupied x", piece_x, px4(1,2,1,2));
      check("rotate occupied y", piece_y, py4(1,1,2,2));
      do_cmd(C_ROTATE, px4(5,6,5,6), py4(17,17,18,18), ok, w);
      check("rotate free ok", ok, 1'b1);
      do_cmd(C_DOWN, '0, '0, ok, w);
      check("down blocked ok", ok, 1'b0);
      tick;
      check("down blocked locked", locked, 1'b1);
      g = g | cb(5,17) | cb(6,17) | cb(5,18) | cb(6,18);
      check("down blocked field", grid, g);
      wait_idle(ROWS + 4, w);

      // Two full rows cleared; rows 17-18 shift into 19-20.
      apply_reset;
      place(px4(1,2,3,4), py4(20,20,20,20), C_DROP, ok);
      place(px4(7,8,9,10), py4(20,20,20,20), C_DROP, ok);
      place(px4(1,2,3,4), py4(19,19,19,19), C_DROP, ok);
      place(px4(7,8,9,10), py4(19,19,19,19), C_DROP, ok);
      place(px4(1,2,9,1), py4(18,18,18,17), C_DROP, ok);
      check("pre-clear lines", lines_cleared, 16'd0);
      place(px4(5,6,5,6), py4(1,1,2,2), C_DROP, ok);
      check("gap drop ok", ok, 1'b1);
      check("lines after clear", lines_cleared, 16'd2);
      check("field after clear", grid, cb(1,20) | cb(2,20) | cb(9,20) | cb(1,19));

      // Reset in the middle of row compaction.
      apply_reset;
      place(px4(1,2,3,4), py4(20,20,20,20), C_DROP, ok);
      place(px4(7,8,9,10), py4(20,20,20,20), C_DROP, ok);
      do_spawn(px4(5,6,5,6), py4(1,1,2,2));
      do_cmd(C_DROP, '0, '0, ok, w);
      tick;
      check("mid-clear locked", locked, 1'b1);
      tick;
      check("mid-clear one shift lines", lines_cleared, 16'd1);
      check("mid-clear one shift field", grid, cb(5,20) | cb(6,20));
      reset = 1'b0;
      tick;
      reset = 1'b1;
      check("mid-clear reset field", grid, '0);
      check("mid-clear reset lines", lines_cleared, 16'd0);
      check("mid-clear reset spawn_ready", spawn_ready, 1'b1);
      check("mid-clear reset game_over", game_over, 1'b0);

      // Rows 1-2 cols 4..7 occupied (locked by blocked DOWN at the floor), then a colliding spawn.
      apply_reset;
      place(px4(4,5,6,1), py4(1,1,1,20), C_DOWN, ok);
      check("floor lock a ok", ok, 1'b0);
      place(px4(7,4,5,2), py4(1,2,2,20), C_DOWN, ok);
      place(px4(6,7,3,8), py4(2,2,20,20), C_DOWN, ok);
      g = cb(4,1) | cb(5,1) | cb(6,1) | cb(7,1) | cb(4,2) | cb(5,2) | cb(6,2) | cb(7,2)
        | cb(1,20) | cb(2,20) | cb(3,20) | cb(8,20);
      check("top field", grid, g);
      do_spawn(px4(5,6,5,6), py4(1,1,2,2));
      check("game_over set", game_over, 1'b1);
      check("over spawn_ready", spawn_ready, 1'b0);
      check("over cmd_ready", cmd_ready, 1'b0);
      check("over piece not loaded", piece_x, '0);
      spawn_x = px4(1,2,1,2);
      spawn_y = py4(1,1,2,2);
      spawn_valid = 1'b1;
      cmd = C_NOP;
      cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) tick;
      spawn_valid = 1'b0;
      cmd_valid = 1'b0;
      check("over sticky", game_over, 1'b1);
      check("over grid frozen", grid, g);
      check("over handshakes ignored", {spawn_ready, cmd_ready, cmd_done}, 3'b000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/playfield_engine.md
Name: playfield_engine

Overview:
- Parametrised successor to the single-piece movement block. Owns the locked playfield plus one active 4-cell piece.
- Accepts spawn and move commands through valid/ready handshakes. Checks bounds and collisions before any move, locks the piece when it lands, then clears full rows one scan step per cycle.
- Sits between the shape generator/rotation logic (upstream) and the display/score logic (downstream).

Parameters:
COLS, 10, playfield width in cells (4..16)
ROWS, 20, playfield height in cells (4..32)
XW, $clog2(COLS+2), x coordinate width (derived)
YW, $clog2(ROWS+2), y coordinate width (derived)
CNT_W, 16, width of the lines-cleared counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
spawn_valid  in  1  new piece offered
spawn_ready  out  1  high only in S_IDLE
spawn_x  in  4*XW  cell x coords, cell i at [i*XW +: XW], 1-based
spawn_y  in  4*YW  cell y coords, 1-based, row 1 = top
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in S_ACTIVE
cmd  in  3  0 NOP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 ROTATE, 5 DROP
rot_x  in  4*XW  candidate coords for ROTATE
rot_y  in  4*YW  candidate coords for ROTATE
cmd_done  out  1  1-cycle pulse: command finished
cmd_ok  out  1  valid with cmd_done: 1 = piece moved
piece_x  out  4*XW  current piece coords
piece_y  out  4*YW  current piece coords
grid  out  ROWS*COLS  locked field OR piece overlay, bit (y-1)*COLS+(x-1)
locked  out  1  1-cycle pulse when the piece merges into the field
lines_cleared  out  CNT_W  total full rows removed, saturating
game_over  out  1  sticky until reset

Behaviour:
- Reset (reset==0 at posedge):
  - field all 0, piece coords all 0, state S_IDLE.
  - All pulses 0, lines_cleared 0, game_over 0.
  - Reset overrides any state, including mid-clear and mid-drop.
- The field stores locked cells only. The piece is overlaid combinationally on grid. Collision tests use the field only, so the piece never needs to exclude itself.
- A cell is "free" when 1<=x<=COLS, 1<=y<=ROWS and its field bit is 0.
- States: S_IDLE, S_ACTIVE, S_DROP, S_LOCK, S_CLEAR, S_OVER.
- S_IDLE, on spawn handshake:
  - All 4 cells free: load the piece, go to S_ACTIVE.
  - Otherwise: set game_over, go to S_OVER. The piece is not loaded.
- S_ACTIVE, on cmd handshake, result registered in 1 cycle (cmd_done/cmd_ok next cycle):
  - LEFT / RIGHT: x∓1 for all 4 cells. Moves if all target cells are free, else cmd_ok=0 and nothing changes.
  - ROTATE: loads rot_x/rot_y if all 4 candidate cells are free, else rejected with no change.
  - DOWN: y+1 if all free, cmd_ok=1. If blocked: cmd_ok=0, go to S_LOCK.
  - DROP: go to S_DROP. cmd_ready stays low until the drop resolves.
  - NOP: cmd_done=1, cmd_ok=1.
- S_DROP: moves the piece down one row per cycle while all cells below are free. When blocked: cmd_done=1, cmd_ok=1 if at least one row was moved, go to S_LOCK.
- S_LOCK: ORs the piece into the field, pulses locked, clears piece coords to 0, sets scan row r=ROWS, goes to S_CLEAR.
- S_CLEAR, one step per cycle:
  - Row r full: rows r..2 take rows r-1..1, row 1 <= 0, lines_cleared +1 (saturating at all-ones), r unchanged (the row is rechecked).
  - Row r not full: r-1.
  - r reaches 0: go to S_IDLE.
  - Worst-case duration: ROWS + 4 cycles.
- S_OVER: absorbing. spawn_ready=0, cmd_ready=0, grid frozen.
- Handshakes made outside their state are ignored. Since ready gates acceptance, no command is ever lost or double-applied.
- Coordinate arithmetic uses YW/XW-bit values. x-1 at x=1 yields 0, which is out of bounds, so the move is rejected; no wrap-around occurs.

Decomposition:
- Package playfield_pkg holds:
  - cmd_e enum (NOP..DROP) and state_e enum.
  - Constant CMD_W=3.
  - Function cell_idx(x,y) returning the grid bit index.
- Sub-module cell_free_check: combinational. Takes the field plus 4 candidate coords and outputs all_free. Three instances: move target, rotate candidate, spawn.
- The row-compaction step stays in the top FSM.

Test Plan:
- Reset, then spawn square {(5,1),(6,1),(5,2),(6,2)} -> spawn_ready falls; piece_y = {1,1,2,2}; grid bits of those cells = 1.
- Square at x 5..6 issues DROP on an empty field -> 18 moves; cmd_done with cmd_ok=1; locked pulse; field rows 19-20 cols 5..6 set; back to S_IDLE within ROWS+4 cycles.
- Piece at x=1 issues LEFT -> cmd_ok=0, coords unchanged. ROTATE into an occupied cell -> cmd_ok=0, no change.
- Rows 19 and 20 pre-filled except cols 5..6; drop square into the gap -> lines_cleared = 2; rows 19-20 now hold the former rows 17-18 contents.
- Field rows 1-2 cols 4..7 occupied; spawn there -> game_over=1 next cycle; spawn_ready=0 and cmd_ready=0 thereafter.
- Assert reset during S_CLEAR mid-shift -> next cycle field = 0, lines_cleared = 0, state S_IDLE, spawn_ready = 1.
